// File: rtl/piano_pkg.sv
// Shared piano definitions: raw mode codes, decoded mode, speaker/LED source
// codes, button indices and the playback FSM state encoding.
package piano_pkg;

   // raw mode switch codes; any other value means "off"
   localparam logic [2:0] MODE_AUTO   = 3'b011;
   localparam logic [2:0] MODE_MANUAL = 3'b001;
   localparam logic [2:0] MODE_STUDY  = 3'b111;

   // button bit positions
   localparam int BTN_PREV  = 0;
   localparam int BTN_PAUSE = 1;
   localparam int BTN_NEXT  = 2;
   localparam int NUM_BTN   = 3;

   typedef enum logic [1:0] {
      MD_OFF, MD_AUTO, MD_MANUAL, MD_STUDY
   } mode_e;

   typedef enum logic [1:0] {
      SRC_NONE  = 2'd0,
      SRC_AUTO  = 2'd1,
      SRC_KEY   = 2'd2,
      SRC_STUDY = 2'd3
   } src_e;

   typedef enum logic [2:0] {
      ST_OFF, ST_MANUAL, ST_PLAY, ST_PAUSED, ST_SWITCH
   } state_e;

   function automatic mode_e decode_mode(input logic [2:0] m);
      case (m)
         MODE_AUTO:   return MD_AUTO;
         MODE_MANUAL: return MD_MANUAL;
         MODE_STUDY:  return MD_STUDY;
         default:     return MD_OFF;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer.
// A raw level is accepted only after it has differed from the accepted level
// for DEB_CYCLES consecutive cycles; press is a one-cycle pulse on acceptance
// of a high level.
// Ports: clk, rst_n (sync, active high), raw (board level),
//        stable (accepted level), press (rising-edge pulse, registered).
module btn_debounce #(
   parameter int DEB_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic press
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic [CW-1:0] count;

   // raw is used directly (no synchronizer stage) so that the press reaches
   // the controller exactly DEB_CYCLES edges after raw rises.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         stable <= 1'b0;
         count  <= '0;
         press  <= 1'b0;
      end else begin
         press <= 1'b0;
         if (raw == stable) begin
            count <= '0;
         end else if (count == CW'(DEB_CYCLES - 1)) begin
            stable <= raw;
            count  <= '0;
            press  <= raw;   // raw != stable here, so raw=1 is a rising edge
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/playback_controller.sv
// Playback controller: debounces prev/pause/next, decodes the mode switch,
// owns song selection and pause state, and picks the speaker/LED source.
// Ports:
//   clk      - system clock
//   rst_n    - synchronous, active-high reset
//   button   - raw buttons [0] prev, [1] pause, [2] next
//   mode     - 011 auto, 001 manual, 111 study, else off
//   song_num - selected song index
//   pause    - auto/study playback frozen
//   restart  - one-cycle pulse, players restart song_num
//   mute     - speaker forced silent
//   src_sel  - 0 none, 1 auto player, 2 keyboard, 3 study
module playback_controller
   import piano_pkg::*;
#(
   parameter  int NUM_SONGS   = 4,
   parameter  int DEB_CYCLES  = 2_000_000,
   parameter  int MUTE_CYCLES = 50_000,
   localparam int SW          = $clog2(NUM_SONGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [2:0]    button,
   input  logic [2:0]    mode,
   output logic [SW-1:0] song_num,
   output logic          pause,
   output logic          restart,
   output logic          mute,
   output logic [1:0]    src_sel
);

   localparam int            MW        = $clog2(MUTE_CYCLES + 1);
   localparam logic [SW-1:0] LAST_SONG = SW'(NUM_SONGS - 1);

   logic [NUM_BTN-1:0] btn_stable, btn_press;
   logic               unused_ok;

   mode_e         mode_q, mode_prev;
   state_e        state, state_n;
   logic [SW-1:0] song_n;
   logic [MW-1:0] mute_cnt, mute_cnt_n;
   logic          restart_n, mute_n, pause_n;
   src_e          src_n;
   logic          step_next, step_prev;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk    (clk),
         .rst_n  (rst_n),
         .raw    (button[i]),
         .stable (btn_stable[i]),
         .press  (btn_press[i])
      );
   end

   // accepted levels are not needed here; only the press pulses are
   assign unused_ok = ^btn_stable;

   always_comb begin
      state_n    = state;
      song_n     = song_num;
      mute_cnt_n = mute_cnt;
      restart_n  = 1'b0;
      // prev and next in the same cycle cancel each other
      step_next  = btn_press[BTN_NEXT] & ~btn_press[BTN_PREV];
      step_prev  = btn_press[BTN_PREV] & ~btn_press[BTN_NEXT];

      if (mode_q != mode_prev) begin
         // mode change outranks every button press this cycle
         unique case (mode_q)
            MD_AUTO, MD_STUDY: begin
               state_n    = ST_SWITCH;
               restart_n  = 1'b1;
               mute_cnt_n = MW'(MUTE_CYCLES);
            end
            MD_MANUAL: state_n = ST_MANUAL;
            default:   state_n = ST_OFF;
         endcase
      end else begin
         case (state)
            ST_PLAY, ST_PAUSED: begin
               if (step_next || step_prev) begin
                  if (step_next)
                     song_n = (song_num == LAST_SONG) ? '0 : song_num + 1'b1;
                  else
                     song_n = (song_num == '0) ? LAST_SONG : song_num - 1'b1;
                  state_n    = ST_SWITCH;
                  restart_n  = 1'b1;
                  mute_cnt_n = MW'(MUTE_CYCLES);
               end else if (btn_press[BTN_PAUSE]) begin
                  state_n = (state == ST_PLAY) ? ST_PAUSED : ST_PLAY;
               end
            end
            ST_SWITCH: begin
               mute_cnt_n = mute_cnt - 1'b1;
               if (mute_cnt == MW'(1)) state_n = ST_PLAY;
            end
            default: ;
         endcase
      end

      // outputs are registered from the next state
      mute_n  = state_n inside {ST_OFF, ST_PAUSED, ST_SWITCH};
      pause_n = (state_n == ST_PAUSED);
      case (state_n)
         ST_OFF:    src_n = SRC_NONE;
         ST_MANUAL: src_n = SRC_KEY;
         default:   src_n = (mode_q == MD_STUDY) ? SRC_STUDY : SRC_AUTO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= ST_OFF;
         song_num  <= '0;
         mute_cnt  <= '0;
         mode_q    <= MD_OFF;
         mode_prev <= MD_OFF;
         pause     <= 1'b0;
         restart   <= 1'b0;
         mute      <= 1'b1;
         src_sel   <= SRC_NONE;
      end else begin
         state     <= state_n;
         song_num  <= song_n;
         mute_cnt  <= mute_cnt_n;
         mode_prev <= mode_q;
         mode_q    <= decode_mode(mode);
         pause     <= pause_n;
         restart   <= restart_n;
         mute      <= mute_n;
         src_sel   <= src_n;
      end
   end

endmodule

// File: tb/tb_playback_controller.sv
module tb_playback_controller;

   localparam int NS = 4, DEB = 4, MUTE = 3;
   localparam int S_OFF = 0, S_MAN = 1, S_PLAY = 2, S_PAUSE = 3, S_SW = 4;
   localparam int MD_OFF = 0, MD_AUTO = 1, MD_MAN = 2, MD_STUDY = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [2:0] button = 3'b000;
   logic [2:0] mode = 3'b000;
   logic [1:0] song_num;
   logic       pause, restart, mute;
   logic [1:0] src_sel;

   always #5 clk = ~clk;

   playback_controller #(.NUM_SONGS(NS), .DEB_CYCLES(DEB), .MUTE_CYCLES(MUTE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .button   (button),
      .mode     (mode),
      .song_num (song_num),
      .pause    (pause),
      .restart  (restart),
      .mute     (mute),
      .src_sel  (src_sel)
   );

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Buttons: a level is taken once raw has held a value different from the
   // accepted level for DEB consecutive cycles (run-length view); the press
   // event it creates is acted on by the controller one cycle later.
   int m_st = S_OFF, m_song = 0, m_left = 0, m_mq = MD_OFF, m_mprev = MD_OFF, m_play = MD_AUTO;
   int m_restart = 0;
   int m_run[3], m_last[3], m_lvl[3], m_prs[3];

   function automatic int dec(input logic [2:0] m);
      case (m)
         3'b011:  return MD_AUTO;
         3'b001:  return MD_MANUAL_f();
         3'b111:  return MD_STUDY;
         default: return MD_OFF;
      endcase
   endfunction

   function automatic int MD_MANUAL_f();
      return MD_MAN;
   endfunction

   function automatic void enter_switch();
      m_st = S_SW;
      m_left = MUTE;
      m_restart = 1;
   endfunction

   function automatic void model_step();
      int nx, pv, pz, r;
      if (rst_n) begin
         m_st = S_OFF; m_song = 0; m_left = 0; m_restart = 0;
         m_mq = MD_OFF; m_mprev = MD_OFF;
         for (int i = 0; i < 3; i++) begin
            m_run[i] = 0; m_last[i] = 0; m_lvl[i] = 0; m_prs[i] = 0;
         end
      end else begin
         pv = m_prs[0]; pz = m_prs[1]; nx = m_prs[2];
         m_restart = 0;
         if (m_mq != m_mprev) begin
            if (m_mq == MD_AUTO || m_mq == MD_STUDY) begin
               m_play = m_mq;
               enter_switch();
            end else if (m_mq == MD_MAN) m_st = S_MAN;
            else m_st = S_OFF;
         end else if (m_st == S_PLAY || m_st == S_PAUSE) begin
            if (nx && !pv) begin
               m_song = (m_song + 1) % NS;
               enter_switch();
            end else if (pv && !nx) begin
               m_song = (m_song + NS - 1) % NS;
               enter_switch();
            end else if (pz) m_st = (m_st == S_PLAY) ? S_PAUSE : S_PLAY;
         end else if (m_st == S_SW) begin
            m_left--;
            if (m_left == 0) m_st = S_PLAY;
         end
         for (int i = 0; i < 3; i++) begin
            r = int'(button[i]);
            m_run[i] = (r == m_last[i]) ? m_run[i] + 1 : 1;
            m_last[i] = r;
            m_prs[i] = 0;
            if (r != m_lvl[i] && m_run[i] >= DEB) begin
               m_lvl[i] = r;
               m_prs[i] = r;
            end
         end
         m_mprev = m_mq;
         m_mq = dec(mode);
      end
   endfunction

   function automatic int e_src();
      if (m_st == S_OFF) return 0;
      if (m_st == S_MAN) return 2;
      return (m_play == MD_STUDY) ? 3 : 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("song", song_num, m_song);
      chk("pause", pause, (m_st == S_PAUSE) ? 1 : 0);
      chk("restart", restart, m_restart);
      chk("mute", mute, (m_st == S_OFF || m_st == S_PAUSE || m_st == S_SW) ? 1 : 0);
      chk("src", src_sel, e_src());
   endtask

   int rst_seen, lat;

   task automatic press(input logic [2:0] mask, input int hold, input int after);
      logic [1:0] s0;
      s0 = song_num; rst_seen = 0; lat = 0;
      button = mask;
      for (int i = 1; i <= hold + after; i++) begin
         if (i == hold + 1) button = 3'b000;
         tick();
         if (restart) rst_seen++;
         if (lat == 0 && song_num !== s0) lat = i;
      end
   endtask

   task automatic wait_song_change(input string tag);
      logic [1:0] s0;
      int found;
      s0 = song_num; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (song_num !== s0) found = 1;
      end
      chk(tag, found, 1);
   endtask

   initial begin
      int mute_len;
      int hold_left[3];
      logic [2:0] modes[7];
      modes = '{3'b011, 3'b111, 3'b001, 3'b000, 3'b010, 3'b011, 3'b111};

      // reset state
      repeat (3) tick();
      chk("rst_song", song_num, 0);
      chk("rst_pause", pause, 0);
      chk("rst_restart", restart, 0);
      chk("rst_mute", mute, 1);
      chk("rst_src", src_sel, 0);
      rst_n = 1'b0;
      tick();

      // 1: enter auto
      mode = 3'b011; rst_seen = 0; mute_len = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (restart) rst_seen++;
         if (mute && src_sel == 2'd1) mute_len++;
      end
      chk("s1_restart", rst_seen, 1);
      chk("s1_mute_len", mute_len, MUTE);
      chk("s1_src", src_sel, 1);
      chk("s1_mute", mute, 0);
      chk("s1_song", song_num, 0);

      // 2: next press latency, then a too-short bounce
      press(3'b100, 6, 8);
      chk("s2_lat", lat, DEB + 1);
      chk("s2_restart", rst_seen, 1);
      chk("s2_song", song_num, 1);
      press(3'b100, 3, 8);
      chk("s2_bounce_song", song_num, 1);
      chk("s2_bounce_restart", rst_seen, 0);

      // 3: wrap both ways
      press(3'b100, 5, 8);
      press(3'b100, 5, 8);
      chk("s3_song3", song_num, 3);
      press(3'b100, 5, 8);
      chk("s3_wrap_up", song_num, 0);
      chk("s3_wrap_up_rs", rst_seen, 1);
      press(3'b001, 5, 8);
      chk("s3_wrap_dn", song_num, 3);
      chk("s3_wrap_dn_rs", rst_seen, 1);

      // 4: pause toggle, prev+next cancel
      press(3'b010, 5, 8);
      chk("s4_pause", pause, 1);
      chk("s4_mute", mute, 1);
      chk("s4_rs1", rst_seen, 0);
      press(3'b010, 5, 8);
      chk("s4_unpause", pause, 0);
      chk("s4_unmute", mute, 0);
      chk("s4_rs2", rst_seen, 0);
      press(3'b101, 5, 8);
      chk("s4_cancel_song", song_num, 3);
      chk("s4_cancel_rs", rst_seen, 0);

      // 5: mode change to manual during SWITCH
      button = 3'b100;
      wait_song_change("s5_switch_seen");
      mode = 3'b001;
      tick(); tick();
      chk("s5_src", src_sel, 2);
      chk("s5_mute", mute, 0);
      chk("s5_pause", pause, 0);
      button = 3'b000;
      repeat (8) tick();
      chk("s5_song", song_num, 0);
      press(3'b100, 5, 8);
      chk("s5_manual_song", song_num, 0);
      chk("s5_manual_rs", rst_seen, 0);

      // 6: reset in the middle of SWITCH
      mode = 3'b011;
      repeat (8) tick();
      chk("s6_src_auto", src_sel, 1);
      press(3'b100, 5, 8);
      chk("s6_song1", song_num, 1);
      button = 3'b100;
      wait_song_change("s6_switch_seen");
      chk("s6_song2", song_num, 2);
      tick();
      rst_n = 1'b1;
      tick();
      chk("s6_rst_song", song_num, 0);
      chk("s6_rst_mute", mute, 1);
      chk("s6_rst_src", src_sel, 0);
      chk("s6_rst_restart", restart, 0);
      chk("s6_rst_pause", pause, 0);
      rst_n = 1'b0; button = 3'b000; mode = 3'b111;
      repeat (8) tick();
      chk("s6_src_study", src_sel, 3);
      chk("s6_song0", song_num, 0);
      chk("s6_mute", mute, 0);

      // random phase, compared cycle by cycle against the model
      for (int i = 0; i < 3; i++) hold_left[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (hold_left[i] == 0) begin
               button[i] = 1'($urandom_range(0, 1));
               hold_left[i] = $urandom_range(1, 7);
            end else hold_left[i]--;
         end
         if ($urandom_range(0, 39) == 0) mode = modes[$urandom_range(0, 6)];
         rst_n = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
